// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter around a shared 32-bit bitwise logic unit (AND/OR/XOR/XNOR/NAND/NOR/NOT/PASS).
// Define LOGIC_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_id_q;
  logic             res_valid_q;
  logic [CNT_W-1:0] done_cnt_q;

  logic             gnt_id;
  logic             idle;
  logic             xfer;
  logic [WIDTH-1:0] alu_res;

`ifdef LOGIC_ARB_RR_EN
  logic last_q;

  // On contention favour whoever did not win the previous transfer.
  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (xfer) begin
      last_q <= gnt_id;
    end
  end
`else
  always_comb begin
    gnt_id = ~req0_valid;
  end
`endif

  // Readies stay low while reset is held so requesters never see a phantom accept.
  assign idle       = (state_q == StIdle) && !rst;
  assign req0_ready = idle && req0_valid && !gnt_id;
  assign req1_ready = idle && req1_valid && gnt_id;
  assign xfer       = req0_ready || req1_ready;

  always_comb begin
    alu_res = '0;
    unique case (op_q)
      3'b000: alu_res = a_q & b_q;
      3'b001: alu_res = a_q | b_q;
      3'b010: alu_res = a_q ^ b_q;
      3'b011: alu_res = ~(a_q ^ b_q);
      3'b100: alu_res = ~(a_q & b_q);
      3'b101: alu_res = ~(a_q | b_q);
      3'b110: alu_res = ~a_q;
      3'b111: alu_res = a_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xfer) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        op_q <= gnt_id ? req1_op : req0_op;
        a_q  <= gnt_id ? req1_a : req0_a;
        b_q  <= gnt_id ? req1_b : req0_b;
        id_q <= gnt_id;
      end
      if (state_q == StExec) begin
        res_data_q  <= alu_res;
        res_id_q    <= id_q;
        res_valid_q <= 1'b1;
      end
      if (state_q == StResp && res_ready) begin
        res_valid_q <= 1'b0;
        done_cnt_q  <= done_cnt_q + CNT_W'(1);
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != StIdle);
  assign done_cnt  = done_cnt_q;

endmodule
